// File: rtl/sat_threshold_counter_if.sv
`default_nettype none
// ============================================================================
// Module      : sat_threshold_counter_if
// Description : Control/status bundle for the saturating threshold counter.
//               The master side drives restart/enable/threshold and observes
//               the count and its flags; the counter itself is the slave.
// Revision    : 1.0 - initial release
// ============================================================================
interface sat_threshold_counter_if #(
    parameter int WIDTH = 3
);
    logic             restart;
    logic             enable;
    logic [WIDTH-1:0] threshold;
    logic [WIDTH-1:0] count;
    logic             Q;
    logic             hit;
    logic             full;

    modport master (
        output restart, enable, threshold,
        input  count, Q, hit, full
    );

    modport slave (
        input  restart, enable, threshold,
        output count, Q, hit, full
    );
endinterface
`default_nettype wire

// File: rtl/sat_threshold_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_threshold_counter
// Description : Saturating up-counter for the input-timing level. Counts
//               enabled edges from 0 up to LIMIT and flags when the count
//               passes a runtime threshold (Q), with a single hit pulse per
//               clear/restart and a full indication at saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_threshold_counter #(
    parameter int WIDTH  = 3,
    parameter int LIMIT  = 7,
    parameter bit STICKY = 1'b1
) (
    input  wire logic              clock,
    input  wire logic              clear,
    sat_threshold_counter_if.slave bus
);
    localparam logic [WIDTH-1:0] c_limit = WIDTH'(LIMIT);
    localparam logic [WIDTH-1:0] c_one   = WIDTH'(1);

    logic [WIDTH-1:0] r_count;
    logic             r_q;
    logic             r_hit;
    logic             r_armed;

    logic             w_at_limit;
    logic             w_event;
    logic [WIDTH-1:0] w_count_next;
    logic             w_q_next;

    // The threshold event looks at the pre-increment count, so Q/hit assert
    // on the same edge that moves count from threshold to threshold+1.
    assign w_at_limit   = (r_count == c_limit);
    assign w_event      = bus.enable && (r_count == bus.threshold);
    assign w_count_next = (bus.enable && !w_at_limit) ? (r_count + c_one) : r_count;

    if (STICKY) begin : g_sticky
        // Latched flag: once the event has occurred it stays until re-armed.
        assign w_q_next = r_q | w_event;
    end else begin : g_level
        // Level compare: follows threshold changes and may drop again.
        assign w_q_next = w_event | (w_count_next > bus.threshold);
    end

    // Count, flag, pulse and re-arm state; clear and restart share one effect.
    always_ff @(posedge clock) begin
        if (clear || bus.restart) begin
            r_count <= '0;
            r_q     <= 1'b0;
            r_hit   <= 1'b0;
            r_armed <= 1'b1;
        end else begin
            r_count <= w_count_next;
            r_q     <= w_q_next;
            r_hit   <= w_event && r_armed;
            if (w_event) begin
                r_armed <= 1'b0;
            end
        end
    end

    assign bus.count = r_count;
    assign bus.Q     = r_q;
    assign bus.hit   = r_hit;
    // full decodes the count register only, so it has no input-to-output path.
    assign bus.full  = w_at_limit;
endmodule
`default_nettype wire

// File: tb/tb_sat_threshold_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sat_threshold_counter
// Description : Self-checking bench for sat_threshold_counter. Three builds
//               (LIMIT=7 sticky, LIMIT=5 sticky, LIMIT=7 level) are exercised
//               by a vector table, directed sequences and random stimulus
//               compared against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sat_threshold_counter;
    localparam int N_DUT = 3;

    typedef struct {
        bit         clr;
        bit         rst;
        bit         en;
        logic [2:0] thr;
        int         exp_count;
        bit         exp_q;
        bit         exp_hit;
        bit         exp_full;
    } vec_t;

    logic       clock;
    logic       clr_s  [N_DUT];
    logic       rst_s  [N_DUT];
    logic       en_s   [N_DUT];
    logic [2:0] thr_s  [N_DUT];
    logic [2:0] cnt_o  [N_DUT];
    logic       q_o    [N_DUT];
    logic       hit_o  [N_DUT];
    logic       full_o [N_DUT];

    int lim_a [N_DUT] = '{7, 5, 7};
    bit st_a  [N_DUT] = '{1'b1, 1'b1, 1'b0};

    // behavioural model state
    int m_count [N_DUT];
    bit m_q     [N_DUT];
    bit m_hit   [N_DUT];
    bit m_armed [N_DUT];

    int n_checks = 0;
    int n_fail   = 0;
    vec_t tbl[$];

    sat_threshold_counter_if #(.WIDTH(3)) bus [N_DUT] ();

    for (genvar g = 0; g < N_DUT; g++) begin : g_link
        assign bus[g].restart   = rst_s[g];
        assign bus[g].enable    = en_s[g];
        assign bus[g].threshold = thr_s[g];
        assign cnt_o[g]         = bus[g].count;
        assign q_o[g]           = bus[g].Q;
        assign hit_o[g]         = bus[g].hit;
        assign full_o[g]        = bus[g].full;
    end

    sat_threshold_counter #(.WIDTH(3), .LIMIT(7), .STICKY(1'b1)) dut0 (
        .clock(clock), .clear(clr_s[0]), .bus(bus[0]));
    sat_threshold_counter #(.WIDTH(3), .LIMIT(5), .STICKY(1'b1)) dut1 (
        .clock(clock), .clear(clr_s[1]), .bus(bus[1]));
    sat_threshold_counter #(.WIDTH(3), .LIMIT(7), .STICKY(1'b0)) dut2 (
        .clock(clock), .clear(clr_s[2]), .bus(bus[2]));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: saturating count, event on enabled edge at count==threshold,
    // one hit per arming, Q either latched or a level comparison.
    function automatic void model_step(int idx, bit c, bit r, bit e, int t);
        bit ev;
        int nxt;
        if (c || r) begin
            m_count[idx] = 0;
            m_q[idx]     = 1'b0;
            m_hit[idx]   = 1'b0;
            m_armed[idx] = 1'b1;
        end else begin
            ev  = e && (m_count[idx] == t);
            nxt = (e && m_count[idx] < lim_a[idx]) ? m_count[idx] + 1 : m_count[idx];
            m_hit[idx] = ev && m_armed[idx];
            if (ev) m_armed[idx] = 1'b0;
            if (st_a[idx]) m_q[idx] = m_q[idx] || ev;
            else           m_q[idx] = ev || (nxt > t);
            m_count[idx] = nxt;
        end
    endfunction

    task automatic drive(input int idx, input bit c, input bit r, input bit e, input logic [2:0] t);
        clr_s[idx] = c;
        rst_s[idx] = r;
        en_s[idx]  = e;
        thr_s[idx] = t;
    endtask

    task automatic cycle();
        @(posedge clock);
        for (int g = 0; g < N_DUT; g++)
            model_step(g, clr_s[g], rst_s[g], en_s[g], int'(thr_s[g]));
        #1;
    endtask

    task automatic check_model(input int idx, input string tag);
        check($sformatf("%s dut%0d count", tag, idx), 32'(cnt_o[idx]), 32'(m_count[idx]));
        check($sformatf("%s dut%0d Q", tag, idx),     32'(q_o[idx]),   32'(m_q[idx]));
        check($sformatf("%s dut%0d hit", tag, idx),   32'(hit_o[idx]), 32'(m_hit[idx]));
        check($sformatf("%s dut%0d full", tag, idx),  32'(full_o[idx]),
              32'(m_count[idx] == lim_a[idx]));
    endtask

    task automatic check_out(input string tag, input int idx, input int c, input bit q,
                             input bit h, input bit f);
        check($sformatf("%s count", tag), 32'(cnt_o[idx]), 32'(c));
        check($sformatf("%s Q", tag),     32'(q_o[idx]),   32'(q));
        check($sformatf("%s hit", tag),   32'(hit_o[idx]), 32'(h));
        check($sformatf("%s full", tag),  32'(full_o[idx]), 32'(f));
    endtask

    function automatic void row(bit c, bit r, bit e, logic [2:0] t, int ec, bit eq, bit eh, bit ef);
        vec_t v;
        v.clr = c; v.rst = r; v.en = e; v.thr = t;
        v.exp_count = ec; v.exp_q = eq; v.exp_hit = eh; v.exp_full = ef;
        tbl.push_back(v);
    endfunction

    initial begin
        // Vector table for the LIMIT=7 sticky build
        row(1, 0, 0, 3'd3, 0, 0, 0, 0);
        for (int i = 1; i <= 10; i++)
            row(0, 0, 1, 3'd3, (i < 7) ? i : 7, i >= 4, i == 4, i >= 7);
        row(1, 0, 0, 3'd3, 0, 0, 0, 0);
        for (int i = 1; i <= 8; i++)
            row(0, 0, (i % 2) == 1, 3'd3, (i + 1) / 2, i >= 7, i == 7, 0);
        row(0, 0, 1, 3'd3, 5, 1, 0, 0);
        row(0, 0, 1, 3'd3, 6, 1, 0, 0);
        row(0, 1, 1, 3'd3, 0, 0, 0, 0);
        for (int i = 1; i <= 5; i++)
            row(0, 0, 1, 3'd3, i, i >= 4, i == 4, 0);
        row(1, 0, 0, 3'd7, 0, 0, 0, 0);
        for (int i = 1; i <= 12; i++)
            row(0, 0, 1, 3'd7, (i < 7) ? i : 7, i >= 8, i == 8, i >= 7);
        row(1, 0, 0, 3'd0, 0, 0, 0, 0);
        row(0, 0, 1, 3'd0, 1, 1, 1, 0);
        row(0, 0, 1, 3'd0, 2, 1, 0, 0);
        row(0, 0, 1, 3'd7, 3, 1, 0, 0);
        row(1, 0, 1, 3'd7, 0, 0, 0, 0);
        row(0, 0, 1, 3'd7, 1, 0, 0, 0);

        for (int g = 0; g < N_DUT; g++) begin
            drive(g, 1'b1, 1'b0, 1'b0, 3'd3);
            m_count[g] = 0; m_q[g] = 0; m_hit[g] = 0; m_armed[g] = 1;
        end
        #2;
        cycle();
        for (int g = 0; g < N_DUT; g++) begin
            check_out($sformatf("reset dut%0d", g), g, 0, 0, 0, 0);
            drive(g, 1'b0, 1'b0, 1'b0, 3'd3);
        end

        foreach (tbl[i]) begin
            drive(0, tbl[i].clr, tbl[i].rst, tbl[i].en, tbl[i].thr);
            cycle();
            check_out($sformatf("tbl[%0d]", i), 0, tbl[i].exp_count, tbl[i].exp_q,
                      tbl[i].exp_hit, tbl[i].exp_full);
            check_model(0, $sformatf("tbl[%0d] model", i));
        end
        drive(0, 1'b0, 1'b0, 1'b0, 3'd3);

        // Unreachable threshold on the LIMIT=5 build
        drive(1, 1'b1, 1'b0, 1'b0, 3'd6);
        cycle();
        check_out("unreach clear", 1, 0, 0, 0, 0);
        for (int i = 1; i <= 10; i++) begin
            drive(1, 1'b0, 1'b0, 1'b1, 3'd6);
            cycle();
            check_out($sformatf("unreach e%0d", i), 1, (i < 5) ? i : 5, 0, 0, i >= 5);
        end
        drive(1, 1'b0, 1'b0, 1'b0, 3'd6);

        // Level-mode flag on the LIMIT=7 non-sticky build
        drive(2, 1'b1, 1'b0, 1'b0, 3'd3);
        cycle();
        check_out("level clear", 2, 0, 0, 0, 0);
        for (int i = 1; i <= 7; i++) begin
            drive(2, 1'b0, 1'b0, 1'b1, 3'd3);
            cycle();
            check_out($sformatf("level e%0d", i), 2, i, i >= 4, i == 4, i == 7);
        end
        drive(2, 1'b0, 1'b0, 1'b1, 3'd7);
        cycle();
        check_out("level thr7 en", 2, 7, 1, 0, 1);
        drive(2, 1'b0, 1'b0, 1'b0, 3'd7);
        cycle();
        check_out("level thr7 idle", 2, 7, 0, 0, 1);
        drive(2, 1'b0, 1'b0, 1'b0, 3'd3);
        cycle();
        check_out("level thr3 idle", 2, 7, 1, 0, 1);
        drive(2, 1'b1, 1'b0, 1'b1, 3'd7);
        cycle();
        check_out("level clear+en", 2, 0, 0, 0, 0);

        // Random stimulus on all builds against the model
        for (int n = 0; n < 600; n++) begin
            for (int g = 0; g < N_DUT; g++) begin
                drive(g,
                      $urandom_range(31) == 0,
                      $urandom_range(23) == 0,
                      $urandom_range(2) != 0,
                      ($urandom_range(3) == 0) ? 3'($urandom_range(7)) : thr_s[g]);
            end
            cycle();
            for (int g = 0; g < N_DUT; g++)
                check_model(g, $sformatf("rand%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
